// File: rtl/acq_pkg.sv
// acq_pkg: shared types and constants for the ADC acquisition slice.
//   acq_state_t          - sequencer state encoding
//   ACQ_SAMPLES_PER_PKT  - default samples per UDP packet
//   ACQ_UDP_LEN          - UDP length field (payload + 8-byte UDP header)
//   ACQ_IP_LEN           - IP total length (payload + 8 UDP + 20 IP)
//   acq_adc_on()         - states in which the ADC data register is enabled
package acq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FRST    = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_ARM     = 3'd3,
      ST_CAPTURE = 3'd4,
      ST_GAP     = 3'd5,
      ST_DONE    = 3'd6
   } acq_state_t;

   localparam int unsigned ACQ_SAMPLES_PER_PKT = 1024;
   localparam int unsigned ACQ_UDP_LEN         = ACQ_SAMPLES_PER_PKT + 8;
   localparam int unsigned ACQ_IP_LEN          = ACQ_SAMPLES_PER_PKT + 28;

   function automatic logic acq_adc_on(input acq_state_t s);
      return (s == ST_ARM) || (s == ST_CAPTURE) || (s == ST_GAP);
   endfunction

endpackage

// File: rtl/acq_phase_timer.sv
// acq_phase_timer: loadable down-counter that stops at zero.
//   clk_32   in  clock
//   rst_n    in  asynchronous active-low reset
//   i_load   in  load i_value this cycle
//   i_value  in  load value (phase length - 1)
//   o_zero   out counter is zero (last cycle of the phase)
module acq_phase_timer #(
   parameter int unsigned W = 4
) (
   input  logic         clk_32,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_value,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk_32 or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= i_value;
      else if (r_cnt != '0)
         r_cnt <= r_cnt - W'(1);
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/acq_sequencer.sv
// acq_sequencer: runs one ADC acquisition: FIFO reset, settle, arm, then
// PKT_COUNT bursts of SAMPLES_PER_PKT FIFO writes separated by GAP_CYCLES.
//   clk_32      in  sample clock
//   rst_n       in  asynchronous active-low reset
//   start       in  one-cycle run request (idle only)
//   abort       in  level, ends the run on the next edge
//   fifo_full   in  capture FIFO full flag
//   fifo_rst    out capture FIFO reset
//   en_adc      out ADC data register enable
//   fifo_wr_en  out FIFO write enable (combinational on fifo_full)
//   busy        out not idle
//   done        out one-cycle pulse on normal completion
//   overrun     out sticky, FIFO full while a write was due
//   pkt_idx     out packets completed in this run
module acq_sequencer
   import acq_pkg::*;
#(
   parameter int unsigned SAMPLES_PER_PKT = ACQ_SAMPLES_PER_PKT,
   parameter int unsigned PKT_COUNT       = 16,
   parameter int unsigned RST_CYCLES      = 8,
   parameter int unsigned SETTLE_CYCLES   = 16,
   parameter int unsigned GAP_CYCLES      = 4
) (
   input  logic        clk_32,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic        fifo_full,
   output logic        fifo_rst,
   output logic        en_adc,
   output logic        fifo_wr_en,
   output logic        busy,
   output logic        done,
   output logic        overrun,
   output logic [15:0] pkt_idx
);

   localparam int unsigned PH_MAX =
      (RST_CYCLES > SETTLE_CYCLES)
         ? ((RST_CYCLES > GAP_CYCLES) ? RST_CYCLES : GAP_CYCLES)
         : ((SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES);
   localparam int unsigned PH_W  = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
   localparam int unsigned SMP_W = (SAMPLES_PER_PKT > 1) ? $clog2(SAMPLES_PER_PKT) : 1;

   localparam logic [PH_W-1:0]  RST_LOAD    = PH_W'(RST_CYCLES - 1);
   localparam logic [PH_W-1:0]  SETTLE_LOAD = PH_W'(SETTLE_CYCLES - 1);
   localparam logic [PH_W-1:0]  GAP_LOAD    = PH_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [SMP_W-1:0] SMP_LAST    = SMP_W'(SAMPLES_PER_PKT - 1);

   acq_state_t       r_state, w_next;
   logic [SMP_W-1:0] r_smp_cnt;
   logic [15:0]      r_pkt_idx;
   logic             r_fifo_rst, r_en_adc, r_busy, r_done, r_overrun;
   logic             w_wr, w_last_wr, w_last_pkt;
   logic             w_tmr_load, w_tmr_zero;
   logic [PH_W-1:0]  w_tmr_val;

   acq_phase_timer #(.W(PH_W)) u_timer (
      .clk_32  (clk_32),
      .rst_n   (rst_n),
      .i_load  (w_tmr_load),
      .i_value (w_tmr_val),
      .o_zero  (w_tmr_zero)
   );

   // Next state and timer loads; the timer is loaded on the edge that
   // enters a timed state, so its zero flag marks that state's last cycle.
   always_comb begin
      w_next     = r_state;
      w_tmr_load = 1'b0;
      w_tmr_val  = '0;
      w_wr       = (r_state == ST_CAPTURE) && !fifo_full;
      w_last_wr  = w_wr && (r_smp_cnt == SMP_LAST);
      w_last_pkt = ((r_pkt_idx + 16'd1) == 16'(PKT_COUNT));
      unique case (r_state)
         ST_IDLE: if (start) begin
            w_next     = ST_FRST;
            w_tmr_load = 1'b1;
            w_tmr_val  = RST_LOAD;
         end
         ST_FRST: if (w_tmr_zero) begin
            w_next     = ST_SETTLE;
            w_tmr_load = 1'b1;
            w_tmr_val  = SETTLE_LOAD;
         end
         ST_SETTLE:  if (w_tmr_zero) w_next = ST_ARM;
         ST_ARM:     w_next = ST_CAPTURE;
         ST_CAPTURE: if (w_last_wr) begin
            if (w_last_pkt)
               w_next = ST_DONE;
            else if (GAP_CYCLES == 0)
               w_next = ST_CAPTURE;
            else begin
               w_next     = ST_GAP;
               w_tmr_load = 1'b1;
               w_tmr_val  = GAP_LOAD;
            end
         end
         ST_GAP:  if (w_tmr_zero) w_next = ST_CAPTURE;
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
      // abort overrides everything, including start in IDLE and the final write
      if (abort)
         w_next = ST_IDLE;
   end

   always_ff @(posedge clk_32 or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_fifo_rst <= 1'b0;
         r_en_adc   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_overrun  <= 1'b0;
         r_pkt_idx  <= '0;
         r_smp_cnt  <= '0;
      end else begin
         r_state    <= w_next;
         // Registered outputs are decoded from the next state so they line
         // up with the state they belong to.
         r_fifo_rst <= (w_next == ST_FRST);
         r_en_adc   <= acq_adc_on(w_next);
         r_busy     <= (w_next != ST_IDLE);
         r_done     <= (w_next == ST_DONE);

         if (r_state == ST_IDLE && start && !abort) begin
            r_overrun <= 1'b0;
            r_pkt_idx <= '0;
         end else if (r_state == ST_CAPTURE && !abort) begin
            if (fifo_full) r_overrun <= 1'b1;
            if (w_last_wr) r_pkt_idx <= r_pkt_idx + 16'd1;
         end

         // Only accepted writes advance the count; a stalled sample is dropped.
         if (r_state != ST_CAPTURE || abort)
            r_smp_cnt <= '0;
         else if (w_wr)
            r_smp_cnt <= w_last_wr ? '0 : r_smp_cnt + SMP_W'(1);
      end
   end

   assign fifo_rst   = r_fifo_rst;
   assign en_adc     = r_en_adc;
   assign fifo_wr_en = w_wr;
   assign busy       = r_busy;
   assign done       = r_done;
   assign overrun    = r_overrun;
   assign pkt_idx    = r_pkt_idx;

endmodule

// File: tb/tb_acq_sequencer.sv
// tb_acq_sequencer: scoreboard bench. Scenarios push expected events
// (fifo_rst cycles, en_adc rise, write cycles, done with pkt_idx/overrun)
// relative to the start cycle; a negedge monitor pops and compares.
module tb_acq_sequencer;

   localparam int K_RST = 0, K_EN = 1, K_WR = 2, K_DONE = 3;

   typedef struct {
      int kind;
      int cyc;
      int pkt;
      int ovr;
   } ev_t;

   ev_t exp_q[$];
   int  n_tests = 0;
   int  n_fail  = 0;

   logic clk_32 = 1'b0;
   logic rst_n = 1'b0, start_a = 1'b0, start_b = 1'b0, abort = 1'b0, fifo_full = 1'b0;

   logic        a_fifo_rst, a_en_adc, a_wr, a_busy, a_done, a_ovr;
   logic [15:0] a_pkt;
   logic        b_fifo_rst, b_en_adc, b_wr, b_busy, b_done, b_ovr;
   logic [15:0] b_pkt;

   int   cyc = 0;
   int   t0  = 0;
   int   rel;
   logic sel     = 1'b0;
   logic mon_en  = 1'b0;
   logic prev_en = 1'b0;

   logic        m_rst, m_en, m_wr, m_done, m_ovr;
   logic [15:0] m_pkt;

   assign m_rst  = sel ? b_fifo_rst : a_fifo_rst;
   assign m_en   = sel ? b_en_adc   : a_en_adc;
   assign m_wr   = sel ? b_wr       : a_wr;
   assign m_done = sel ? b_done     : a_done;
   assign m_ovr  = sel ? b_ovr      : a_ovr;
   assign m_pkt  = sel ? b_pkt      : a_pkt;

   acq_sequencer #(
      .SAMPLES_PER_PKT (4),
      .PKT_COUNT       (2),
      .RST_CYCLES      (2),
      .SETTLE_CYCLES   (3),
      .GAP_CYCLES      (2)
   ) dut (
      .clk_32     (clk_32),
      .rst_n      (rst_n),
      .start      (start_a),
      .abort      (abort),
      .fifo_full  (fifo_full),
      .fifo_rst   (a_fifo_rst),
      .en_adc     (a_en_adc),
      .fifo_wr_en (a_wr),
      .busy       (a_busy),
      .done       (a_done),
      .overrun    (a_ovr),
      .pkt_idx    (a_pkt)
   );

   acq_sequencer #(
      .SAMPLES_PER_PKT (4),
      .PKT_COUNT       (2),
      .RST_CYCLES      (2),
      .SETTLE_CYCLES   (3),
      .GAP_CYCLES      (0)
   ) dut_nogap (
      .clk_32     (clk_32),
      .rst_n      (rst_n),
      .start      (start_b),
      .abort      (abort),
      .fifo_full  (fifo_full),
      .fifo_rst   (b_fifo_rst),
      .en_adc     (b_en_adc),
      .fifo_wr_en (b_wr),
      .busy       (b_busy),
      .done       (b_done),
      .overrun    (b_ovr),
      .pkt_idx    (b_pkt)
   );

   always #5 clk_32 = ~clk_32;
   always @(posedge clk_32) cyc <= cyc + 1;

   task automatic check_ev(input int kind, input int c, input int pkt, input int ovr);
      ev_t e;
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_event kind=%0d cycle=%0d, required: no event", kind, c);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.cyc != c ||
             (kind == K_DONE && (e.pkt != pkt || e.ovr != ovr))) begin
            n_fail++;
            $display("FAIL event got kind=%0d cycle=%0d pkt=%0d ovr=%0d, required kind=%0d cycle=%0d pkt=%0d ovr=%0d",
                     kind, c, pkt, ovr, e.kind, e.cyc, e.pkt, e.ovr);
         end
      end
   endtask

   always @(negedge clk_32) begin
      if (mon_en) begin
         rel = cyc - t0;
         if (m_rst)             check_ev(K_RST, rel, 0, 0);
         if (m_en && !prev_en)  check_ev(K_EN, rel, 0, 0);
         if (m_wr)              check_ev(K_WR, rel, 0, 0);
         if (m_done)            check_ev(K_DONE, rel, int'(m_pkt), int'(m_ovr));
      end
      prev_en = m_en;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic push(input int k, input int c, input int p = 0, input int o = 0);
      ev_t e;
      e.kind = k; e.cyc = c; e.pkt = p; e.ovr = o;
      exp_q.push_back(e);
   endtask

   task automatic push_writes(input int first, input int last);
      for (int i = first; i <= last; i++) push(K_WR, i);
   endtask

   task automatic push_prologue();
      push(K_RST, 1);
      push(K_RST, 2);
      push(K_EN, 6);
   endtask

   task automatic start_run(input logic which);
      @(posedge clk_32); #1;
      t0 = cyc;
      if (which) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clk_32); #1;
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic wait_to(input int k);
      while ((cyc - t0) < k) begin
         @(posedge clk_32); #1;
      end
   endtask

   task automatic chk_drained(input string name);
      chk(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      repeat (3) @(posedge clk_32);
      #1;
      chk("rst_fifo_rst", int'(a_fifo_rst), 0);
      chk("rst_en_adc",   int'(a_en_adc), 0);
      chk("rst_wr_en",    int'(a_wr), 0);
      chk("rst_busy",     int'(a_busy), 0);
      chk("rst_done",     int'(a_done), 0);
      chk("rst_overrun",  int'(a_ovr), 0);
      chk("rst_pkt_idx",  int'(a_pkt), 0);
      chk("rst_b_busy",   int'(b_busy), 0);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // nominal run
      sel = 1'b0;
      push_prologue();
      push_writes(7, 10);
      push_writes(13, 16);
      push(K_DONE, 17, 2, 0);
      start_run(1'b0);
      wait_to(30);
      chk_drained("nominal_pending");
      chk("nominal_busy", int'(a_busy), 0);
      chk("nominal_pkt_idx", int'(a_pkt), 2);

      // backpressure on cycles 8-9
      push_prologue();
      push(K_WR, 7);
      push_writes(10, 12);
      push_writes(15, 18);
      push(K_DONE, 19, 2, 1);
      start_run(1'b0);
      wait_to(8);
      fifo_full = 1'b1;
      wait_to(10);
      fifo_full = 1'b0;
      wait_to(32);
      chk_drained("bp_pending");
      chk("bp_overrun_sticky", int'(a_ovr), 1);

      // abort during second packet
      push_prologue();
      push_writes(7, 10);
      push_writes(13, 14);
      start_run(1'b0);
      wait_to(14);
      abort = 1'b1;
      wait_to(15);
      chk("abort_busy",     int'(a_busy), 0);
      chk("abort_en_adc",   int'(a_en_adc), 0);
      chk("abort_fifo_rst", int'(a_fifo_rst), 0);
      chk("abort_wr_en",    int'(a_wr), 0);
      chk("abort_done",     int'(a_done), 0);
      chk("abort_pkt_idx",  int'(a_pkt), 1);
      chk("abort_overrun",  int'(a_ovr), 0);
      abort = 1'b0;
      wait_to(30);
      chk_drained("abort_pending");
      chk("abort_pkt_hold", int'(a_pkt), 1);

      // start while busy is ignored
      push_prologue();
      push_writes(7, 10);
      push_writes(13, 16);
      push(K_DONE, 17, 2, 0);
      start_run(1'b0);
      wait_to(9);
      start_a = 1'b1;
      wait_to(10);
      start_a = 1'b0;
      wait_to(35);
      chk_drained("restart_pending");
      chk("restart_busy", int'(a_busy), 0);

      // asynchronous reset mid-run
      push_prologue();
      push_writes(7, 10);
      start_run(1'b0);
      wait_to(12);
      chk("pre_reset_pkt_idx", int'(a_pkt), 1);
      rst_n = 1'b0;
      #1;
      chk("areset_busy",    int'(a_busy), 0);
      chk("areset_en_adc",  int'(a_en_adc), 0);
      chk("areset_wr_en",   int'(a_wr), 0);
      chk("areset_pkt_idx", int'(a_pkt), 0);
      wait_to(15);
      rst_n = 1'b1;
      wait_to(35);
      chk_drained("areset_pending");
      chk("areset_stay_idle", int'(a_busy), 0);

      // no-gap build
      sel = 1'b1;
      push_prologue();
      push_writes(7, 14);
      push(K_DONE, 15, 2, 0);
      start_run(1'b1);
      wait_to(30);
      chk_drained("nogap_pending");
      chk("nogap_pkt_idx", int'(b_pkt), 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
